// File: rtl/el2_trace_fifo.sv
// el2_trace_fifo: elastic buffer between the core's retirement trace packet
// and an external valid/ready trace sink. It drops packets when full, counts
// the drops in a saturating counter, and tags the first packet accepted after
// a loss so the sink can resynchronise.
//
// trace_pkt layout (el2_trace_pkt_t, msb first):
//   [103:72] insn, [71:40] address, [39] valid, [38] exception,
//   [37:33] ecause, [32] interrupt, [31:0] tval
module el2_trace_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       trace_en,
  input  logic [103:0]               trace_pkt,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic [31:0]                tr_insn,
  output logic [31:0]                tr_addr,
  output logic                       tr_exception,
  output logic [4:0]                 tr_ecause,
  output logic                       tr_interrupt,
  output logic [31:0]                tr_tval,
  output logic                       tr_lost,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                drop_cnt,
  input  logic                       drop_cnt_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] address;
    logic        valid;
    logic        exception;
    logic [4:0]  ecause;
    logic        interrupt;
    logic [31:0] tval;
  } el2_trace_pkt_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exception;
    logic [4:0]  ecause;
    logic        interrupt;
    logic [31:0] tval;
    logic        lost;
  } entry_t;

  el2_trace_pkt_t pkt;
  entry_t         wr_entry;
  entry_t         head;
  entry_t         mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          lost_pend;

  logic push_req;
  logic pop;
  logic full;
  logic accept;
  logic drop;

  assign pkt      = el2_trace_pkt_t'(trace_pkt);
  assign tr_valid = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign push_req = trace_en & pkt.valid;
  assign pop      = tr_valid & tr_ready;
  // A pop frees the head slot at the same edge, so a full FIFO can still accept.
  assign accept   = push_req & (~full | pop);
  assign drop     = push_req & ~accept;

  assign wr_entry = '{insn:      pkt.insn,
                      addr:      pkt.address,
                      exception: pkt.exception,
                      ecause:    pkt.ecause,
                      interrupt: pkt.interrupt,
                      tval:      pkt.tval,
                      lost:      lost_pend};

  // Control state: pointers, occupancy, pending-loss flag and drop counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      lost_pend <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(accept) - CW'(pop);

      if (accept)    lost_pend <= 1'b0;
      else if (drop) lost_pend <= 1'b1;

      if (drop_cnt_clr)                drop_cnt <= {15'd0, drop};
      else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Entry storage: written only on an accepted push.
  // NOTE: the array has no reset; stale contents are unreachable because
  // count/pointers are reset and outputs are masked while tr_valid is low.
  always_ff @(posedge clk) begin
    if (rst_l && accept) mem[wr_ptr] <= wr_entry;
  end

  assign head = mem[rd_ptr];

  // Head outputs, forced to zero while the FIFO is empty.
  // NOTE: every output gets a default first so no latch can be inferred.
  always_comb begin
    tr_insn      = '0;
    tr_addr      = '0;
    tr_exception = 1'b0;
    tr_ecause    = '0;
    tr_interrupt = 1'b0;
    tr_tval      = '0;
    tr_lost      = 1'b0;
    if (tr_valid) begin
      tr_insn      = head.insn;
      tr_addr      = head.addr;
      tr_exception = head.exception;
      tr_ecause    = head.ecause;
      tr_interrupt = head.interrupt;
      tr_tval      = head.tval;
      tr_lost      = head.lost;
    end
  end

endmodule

// File: tb/tb_el2_trace_fifo.sv
// Scoreboard bench for el2_trace_fifo: directed stimulus queues the expected
// sink transfers; a monitor compares every head handed to the sink.
module tb_el2_trace_fifo;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] address;
    logic        valid;
    logic        exception;
    logic [4:0]  ecause;
    logic        interrupt;
    logic [31:0] tval;
  } pkt_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exception;
    logic [4:0]  ecause;
    logic        interrupt;
    logic [31:0] tval;
    logic        lost;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        trace_en;
  pkt_t        pkt;
  logic        tr_valid;
  logic        tr_ready;
  logic [31:0] tr_insn;
  logic [31:0] tr_addr;
  logic        tr_exception;
  logic [4:0]  tr_ecause;
  logic        tr_interrupt;
  logic [31:0] tr_tval;
  logic        tr_lost;
  logic [3:0]  count;
  logic [15:0] drop_cnt;
  logic        drop_cnt_clr;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  el2_trace_fifo #(.DEPTH(8)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .trace_en     (trace_en),
    .trace_pkt    (pkt),
    .tr_valid     (tr_valid),
    .tr_ready     (tr_ready),
    .tr_insn      (tr_insn),
    .tr_addr      (tr_addr),
    .tr_exception (tr_exception),
    .tr_ecause    (tr_ecause),
    .tr_interrupt (tr_interrupt),
    .tr_tval      (tr_tval),
    .tr_lost      (tr_lost),
    .count        (count),
    .drop_cnt     (drop_cnt),
    .drop_cnt_clr (drop_cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Side-band fields derived from the address so every field is exercised.
  function automatic pkt_t mk(input logic [31:0] insn, input logic [31:0] addr);
    pkt_t p;
    p.insn      = insn;
    p.address   = addr;
    p.valid     = 1'b1;
    p.exception = addr[0];
    p.ecause    = addr[6:2];
    p.interrupt = addr[1];
    p.tval      = addr ^ 32'hA5A5_0000;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one valid packet for one edge; queue it if it should be accepted.
  task automatic send(input logic [31:0] insn, input logic [31:0] addr,
                      input bit acc, input bit lost);
    pkt_t p;
    exp_t e;
    p = mk(insn, addr);
    pkt = p;
    if (acc) begin
      e = '{insn: p.insn, addr: p.address, exception: p.exception,
            ecause: p.ecause, interrupt: p.interrupt, tval: p.tval, lost: lost};
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic idle();
    pkt = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    tr_ready = 1'b1;
    while (count != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_empty", 128'(count), 128'd0);
  endtask

  // Monitor: every head taken by the sink must match the scoreboard front.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (rst_l && tr_valid && tr_ready) begin
      act = '{insn: tr_insn, addr: tr_addr, exception: tr_exception,
              ecause: tr_ecause, interrupt: tr_interrupt, tval: tr_tval, lost: tr_lost};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop: got addr %0h lost %0b, expected no transfer",
                 act.addr, act.lost);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL sink_pkt: got addr %0h insn %0h lost %0b tval %0h, expected addr %0h insn %0h lost %0b tval %0h",
                   act.addr, act.insn, act.lost, act.tval, e.addr, e.insn, e.lost, e.tval);
        end
      end
    end
  end

  initial begin
    rst_l        = 1'b0;
    trace_en     = 1'b1;
    pkt          = '0;
    tr_ready     = 1'b0;
    drop_cnt_clr = 1'b0;
    repeat (2) tick();
    rst_l = 1'b1;
    check("rst_valid", 128'(tr_valid), 128'd0);
    check("rst_count", 128'(count), 128'd0);
    check("rst_drop", 128'(drop_cnt), 128'd0);

    // Single packet: visible one cycle after the push, gone after the pop.
    tr_ready = 1'b1;
    send(32'h0000_0013, 32'h8000_0000, 1'b1, 1'b0);
    idle();
    check("single_valid", 128'(tr_valid), 128'd1);
    check("single_insn", 128'(tr_insn), 128'h13);
    check("single_addr", 128'(tr_addr), 128'h8000_0000);
    check("single_lost", 128'(tr_lost), 128'd0);
    tick();
    check("single_gone", 128'(tr_valid), 128'd0);
    check("idle_data_zero",
          128'({tr_insn, tr_addr, tr_exception, tr_ecause, tr_interrupt, tr_tval, tr_lost}),
          128'd0);

    // Fill, overflow and recover: 0..7 stored, 8..10 dropped, 11 tagged lost.
    tr_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(32'h13 + 32'(i), 32'(i), i < 8, 1'b0);
    idle();
    check("fill_count", 128'(count), 128'd8);
    check("fill_drop", 128'(drop_cnt), 128'd3);
    check("fill_head_stable", 128'(tr_addr), 128'd0);
    tr_ready = 1'b1;
    send(32'h13 + 32'd11, 32'd11, 1'b1, 1'b1);
    idle();
    check("recover_count", 128'(count), 128'd8);
    check("recover_drop", 128'(drop_cnt), 128'd3);
    drain();

    // Full with simultaneous push and pop.
    tr_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(i), 32'h100 + 32'(i), 1'b1, 1'b0);
    check("full_count", 128'(count), 128'd8);
    tr_ready = 1'b1;
    send(32'h108, 32'h108, 1'b1, 1'b0);
    check("fullpp_count", 128'(count), 128'd8);
    send(32'h109, 32'h109, 1'b1, 1'b0);
    idle();
    check("fullpp_count2", 128'(count), 128'd8);
    check("fullpp_drop", 128'(drop_cnt), 128'd3);
    drain();

    // Counter saturation and clear.
    drop_cnt_clr = 1'b1;
    tick();
    drop_cnt_clr = 1'b0;
    check("clr_start", 128'(drop_cnt), 128'd0);
    tr_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h200 + 32'(i), 32'h200 + 32'(i), 1'b1, 1'b0);
    pkt = mk(32'h2ff, 32'h2ff);
    repeat (65540) tick();
    check("sat_drop", 128'(drop_cnt), 128'hFFFF);
    tick();
    check("sat_hold", 128'(drop_cnt), 128'hFFFF);
    drop_cnt_clr = 1'b1;
    tick();
    check("clr_with_drop", 128'(drop_cnt), 128'd1);
    idle();
    tick();
    drop_cnt_clr = 1'b0;
    check("clr_alone", 128'(drop_cnt), 128'd0);
    drain();

    // Enable gating: lost_pend from the drops above tags the first entry.
    tr_ready = 1'b0;
    send(32'h300, 32'h300, 1'b1, 1'b1);
    send(32'h301, 32'h301, 1'b1, 1'b0);
    send(32'h302, 32'h302, 1'b1, 1'b0);
    idle();
    check("gate_count3", 128'(count), 128'd3);
    trace_en = 1'b0;
    tr_ready = 1'b1;
    pkt = mk(32'h3ff, 32'h3ff);
    repeat (5) tick();
    check("gate_count0", 128'(count), 128'd0);
    check("gate_drop", 128'(drop_cnt), 128'd0);
    idle();
    trace_en = 1'b1;

    // Reset mid-operation with five entries queued and a loss pending.
    tr_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h400 + 32'(i), 32'h400 + 32'(i), 1'b1, 1'b0);
    send(32'h408, 32'h408, 1'b0, 1'b0);
    idle();
    tr_ready = 1'b1;
    repeat (3) tick();
    tr_ready = 1'b0;
    check("pre_rst_count", 128'(count), 128'd5);
    rst_l = 1'b0;
    sb.delete();
    tick();
    rst_l = 1'b1;
    check("mid_rst_count", 128'(count), 128'd0);
    check("mid_rst_valid", 128'(tr_valid), 128'd0);
    check("mid_rst_drop", 128'(drop_cnt), 128'd0);
    tr_ready = 1'b1;
    send(32'h500, 32'h500, 1'b1, 1'b0);
    idle();
    drain();

    check("sb_empty", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/el2_trace_fifo.md
# el2_trace_fifo

Elastic buffer between the core's per-retirement trace packet (`el2_trace_pkt_t`, produced by the decode/TLU stage) and an external trace sink with a valid/ready handshake. It absorbs sink back-pressure, drops packets when full, and counts the drops. The first packet accepted after any loss is tagged so the sink can resynchronise. Instantiated at the core boundary, directly downstream of the trace packet source.

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥ 2
- `clk`  in  1  core clock
- `rst_l`  in  1  reset; synchronous, active-low
- `trace_en`  in  1  capture enable; 0 blocks pushes and drop counting
- `trace_pkt`  in  104 (`el2_trace_pkt_t`)  source packet; `trace_rv_i_valid_ip` is the push request
- `tr_valid`  out  1  head entry present
- `tr_ready`  in  1  sink accepts head this cycle
- `tr_insn`  out  32  head instruction
- `tr_addr`  out  32  head PC
- `tr_exception`  out  1  head exception flag
- `tr_ecause`  out  5  head cause
- `tr_interrupt`  out  1  head interrupt flag
- `tr_tval`  out  32  head tval
- `tr_lost`  out  1  ≥1 packet was dropped immediately before this entry
- `count`  out  $clog2(DEPTH+1)  occupied entries
- `drop_cnt`  out  16  saturating dropped-packet counter
- `drop_cnt_clr`  in  1  clear `drop_cnt`

## Operation
- Storage: DEPTH × 104 bits. Each entry holds insn, addr, exception, ecause, interrupt, tval, lost. Circular buffer with wr_ptr, rd_ptr and count registers.
- push_req = `trace_en` & `trace_pkt.trace_rv_i_valid_ip`.
- pop = `tr_valid` & `tr_ready`.
- Push accepted when push_req & ((count < DEPTH) | pop). A full FIFO with a simultaneous pop accepts the push.
- Drop = push_req & ~accepted. A drop:
  - does not change the storage or the pointers;
  - increments `drop_cnt` unless it is already 0xFFFF;
  - sets the sticky `lost_pend`.
- An accepted push writes `lost` = `lost_pend` into the entry and clears `lost_pend` in the same cycle.
- `count` next value = count + accepted − pop. Pointers wrap modulo DEPTH.
- `tr_valid` = (count ≠ 0).
- Head outputs are read from the rd_ptr entry. All `tr_*` data outputs are forced to 0 while `tr_valid` = 0.
- The sink must not see head data change while `tr_valid` & ~`tr_ready`.
- `drop_cnt_clr`:
  - Has priority over increment.
  - If clr and a drop occur in the same cycle, `drop_cnt` becomes 1.
  - Does not affect `lost_pend`.
- `trace_en` = 0:
  - no pushes and no drops;
  - pops continue;
  - `lost_pend` is held.
- Reset (rst_l = 0 at a clk edge):
  - pointers, count, `lost_pend` and `drop_cnt` are set to 0;
  - all outputs read 0 the following cycle;
  - in-flight entries are discarded, with no partial state.

## Timing
- Push-to-visible latency is 1 cycle. A packet accepted at edge N drives `tr_valid` = 1 after edge N, when the FIFO was empty.
- Pop takes effect at the edge where `tr_valid` & `tr_ready` are sampled. The next entry, if any, appears in the same cycle as the updated pointer.
- Sustained throughput is 1 packet/cycle with `tr_ready` held high.
- A simultaneous push and pop on an empty FIFO is impossible, because pop requires `tr_valid`.
- A simultaneous push and pop when count = 1 leaves count = 1; the new entry becomes the head next cycle.
- All outputs are registered or decoded from registers. There is no combinational path from `trace_pkt` to any `tr_*` output.
- The only combinational path from `tr_ready` is into the internal accept logic; it does not reach any output.

## Test plan
- Single packet:
  - stimulus: reset, `tr_ready` = 1, push insn=0x00000013, addr=0x80000000;
  - response: next cycle `tr_valid` = 1, `tr_insn` = 0x13, `tr_addr` = 0x80000000, `tr_lost` = 0; the cycle after, `tr_valid` = 0 and all data outputs are 0.
- Fill, overflow and recover (DEPTH = 8):
  - stimulus: `tr_ready` = 0, push 11 packets with addr = 0..10; then `tr_ready` = 1 and push addr = 11;
  - response: count saturates at 8, `drop_cnt` = 3; the sink receives addr 0..7 with `tr_lost` = 0, then addr 11 with `tr_lost` = 1.
- Full with simultaneous push and pop:
  - stimulus: count = 8, `tr_ready` = 1 and a push in the same cycle;
  - response: the push is accepted, count stays 8, `drop_cnt` is unchanged, order is preserved.
- Counter saturation and clear:
  - stimulus: preload via 65 540 drops;
  - response: `drop_cnt` = 0xFFFF and holds. A clear together with a drop gives `drop_cnt` = 1; a clear alone gives 0.
- Enable gating:
  - stimulus: `trace_en` = 0 with 5 valid packets while 3 entries are queued and `tr_ready` = 1;
  - response: the 3 entries drain, `drop_cnt` stays 0, count reaches 0.
- Reset mid-operation:
  - stimulus: count = 5 and `lost_pend` = 1, assert `rst_l` = 0 for one edge, then push one packet;
  - response: after reset count = 0, `tr_valid` = 0, `drop_cnt` = 0; the new packet emerges with `tr_lost` = 0.
